// File: rtl/hist_eq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hist_eq_pkg : shared constants and types for the hist-eq param ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hist_eq_pkg;
  localparam int BOUND_W = 10;

  localparam logic [1:0] CFG_ADDR_THR   = 2'd0;
  localparam logic [1:0] CFG_ADDR_UPPER = 2'd1;
  localparam logic [1:0] CFG_ADDR_LOWER = 2'd2;
  localparam logic [1:0] CFG_ADDR_CTRL  = 2'd3;

  localparam int CTRL_THR_EN  = 0;
  localparam int CTRL_COMMIT  = 8;
  localparam int CTRL_ERR_CLR = 9;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } snoop_state_t;
endpackage
`default_nettype wire

// File: rtl/hist_eq_frame_stats.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hist_eq_frame_stats : stream snoop FSM with frame and line counters  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hist_eq_frame_stats
  import hist_eq_pkg::*;
(
  input  logic        i_sys_clk,
  input  logic        i_sys_aresetn,
  input  logic        beat,
  input  logic        sof,
  input  logic        tlast,
  output logic [15:0] frame_cnt,
  output logic [15:0] lines_last_frame
);

  snoop_state_t r_state, w_state_nxt;
  logic [15:0]  r_line_cnt;
  logic [15:0]  r_frame_cnt;
  logic [15:0]  r_lines_last;

  always_comb begin
    w_state_nxt = r_state;
    if (beat && sof) w_state_nxt = IN_FRAME;
  end

  // The first SOF after reset only synchronises; frames are counted from the second.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_state      <= WAIT_SOF;
      r_line_cnt   <= 16'd0;
      r_frame_cnt  <= 16'd0;
      r_lines_last <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (beat) begin
        if (sof) begin
          r_line_cnt <= 16'd0;
          if (r_state == IN_FRAME) begin
            r_lines_last <= r_line_cnt;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
          end
        end else if (tlast && (r_state == IN_FRAME) && (r_line_cnt != 16'hFFFF)) begin
          r_line_cnt <= r_line_cnt + 16'd1;
        end
      end
    end
  end

  assign frame_cnt        = r_frame_cnt;
  assign lines_last_frame = r_lines_last;

endmodule
`default_nettype wire

// File: rtl/hist_eq_param_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | hist_eq_param_ctrl : staged parameters committed atomically on SOF   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hist_eq_param_ctrl
  import hist_eq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEF_THR    = 128,
  parameter int DEF_UPPER  = 717,
  parameter int DEF_LOWER  = 205
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic                  cfg_wr_en,
  input  logic [1:0]            cfg_addr,
  input  logic [15:0]           cfg_wr_data,
  input  logic                  snoop_tvalid,
  input  logic                  snoop_tready,
  input  logic                  snoop_tuser,
  input  logic                  snoop_tlast,
  output logic [DATA_WIDTH-1:0] contrast_threshold_param,
  output logic [BOUND_W-1:0]    upper_bound_param,
  output logic [BOUND_W-1:0]    lower_bound_param,
  output logic                  thresholding_en,
  output logic                  cfg_pending,
  output logic                  cfg_applied,
  output logic                  cfg_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           lines_last_frame
);

  localparam logic [DATA_WIDTH-1:0] C_DEF_THR   = DATA_WIDTH'(DEF_THR);
  localparam logic [BOUND_W-1:0]    C_DEF_UPPER = BOUND_W'(DEF_UPPER);
  localparam logic [BOUND_W-1:0]    C_DEF_LOWER = BOUND_W'(DEF_LOWER);

  logic                  w_beat, w_sof, w_commit, w_bounds_ok;
  logic                  w_wr_ctrl, w_arm, w_err_clr;
  logic [DATA_WIDTH-1:0] r_stg_thr, r_act_thr;
  logic [BOUND_W-1:0]    r_stg_upper, r_stg_lower, r_act_upper, r_act_lower;
  logic                  r_stg_en, r_act_en;
  logic                  r_pending, r_applied, r_err;
  logic                  w_unused;

  assign w_beat      = snoop_tvalid & snoop_tready;
  assign w_sof       = w_beat & snoop_tuser;
  assign w_commit    = w_sof & r_pending;
  assign w_bounds_ok = r_stg_lower < r_stg_upper;
  assign w_wr_ctrl   = cfg_wr_en && (cfg_addr == CFG_ADDR_CTRL);
  assign w_arm       = w_wr_ctrl & cfg_wr_data[CTRL_COMMIT];
  assign w_err_clr   = w_wr_ctrl & cfg_wr_data[CTRL_ERR_CLR];
  assign w_unused    = ^cfg_wr_data[15:10];

  // Commit reads staging registers before this cycle's write lands.
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_stg_thr   <= C_DEF_THR;
      r_stg_upper <= C_DEF_UPPER;
      r_stg_lower <= C_DEF_LOWER;
      r_stg_en    <= 1'b1;
      r_act_thr   <= C_DEF_THR;
      r_act_upper <= C_DEF_UPPER;
      r_act_lower <= C_DEF_LOWER;
      r_act_en    <= 1'b1;
      r_pending   <= 1'b0;
      r_applied   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_applied <= 1'b0;
      if (cfg_wr_en) begin
        case (cfg_addr)
          CFG_ADDR_THR:   r_stg_thr   <= cfg_wr_data[DATA_WIDTH-1:0];
          CFG_ADDR_UPPER: r_stg_upper <= cfg_wr_data[BOUND_W-1:0];
          CFG_ADDR_LOWER: r_stg_lower <= cfg_wr_data[BOUND_W-1:0];
          default:        r_stg_en    <= cfg_wr_data[CTRL_THR_EN];
        endcase
      end
      if (w_err_clr) r_err <= 1'b0;
      if (w_commit) begin
        r_pending <= 1'b0;
        if (w_bounds_ok) begin
          r_act_thr   <= r_stg_thr;
          r_act_upper <= r_stg_upper;
          r_act_lower <= r_stg_lower;
          r_act_en    <= r_stg_en;
          r_applied   <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
      // An arm coinciding with an SOF survives that SOF and waits for the next.
      if (w_arm) r_pending <= 1'b1;
    end
  end

  hist_eq_frame_stats u_frame_stats (
    .i_sys_clk        (i_sys_clk),
    .i_sys_aresetn    (i_sys_aresetn),
    .beat             (w_beat),
    .sof              (snoop_tuser),
    .tlast            (snoop_tlast),
    .frame_cnt        (frame_cnt),
    .lines_last_frame (lines_last_frame)
  );

  assign contrast_threshold_param = r_act_thr;
  assign upper_bound_param        = r_act_upper;
  assign lower_bound_param        = r_act_lower;
  assign thresholding_en          = r_act_en;
  assign cfg_pending              = r_pending;
  assign cfg_applied              = r_applied;
  assign cfg_err                  = r_err;

endmodule
`default_nettype wire

// File: doc/hist_eq_param_ctrl.md
Name: hist_eq_param_ctrl

Overview:
Configuration controller for the histogram-equalization pixel pipeline.
- Host software writes threshold, bound and mode parameters into staging registers through a simple write port.
- The block commits them atomically to the pipeline's parameter inputs, only on a start-of-frame beat of the input AXI-Stream, so a frame is never processed with mixed parameters.
- It also snoops the stream to report frame and line counts and a sticky configuration-error flag.

Parameters:
DATA_WIDTH, 8, pixel width; also the width of the contrast threshold.
DEF_THR, 128, reset value of the contrast threshold.
DEF_UPPER, 717, reset value of the upper bound (units of 1/1024).
DEF_LOWER, 205, reset value of the lower bound (units of 1/1024).

Ports:
i_sys_clk  in  1  system clock; the only clock.
i_sys_aresetn  in  1  reset, asynchronous, active-low.
cfg_wr_en  in  1  write strobe, one cycle per write.
cfg_addr  in  2  register address.
cfg_wr_data  in  16  write data.
snoop_tvalid  in  1  tvalid of the pipeline input stream.
snoop_tready  in  1  tready of the pipeline input stream.
snoop_tuser  in  1  tuser (start of frame) of the pipeline input stream.
snoop_tlast  in  1  tlast (end of line) of the pipeline input stream.
contrast_threshold_param  out  DATA_WIDTH  active contrast threshold.
upper_bound_param  out  10  active upper bound.
lower_bound_param  out  10  active lower bound.
thresholding_en  out  1  active mode: 1 = mask output, 0 = contrasted image.
cfg_pending  out  1  a commit is armed and waiting for the next start of frame.
cfg_applied  out  1  one-cycle pulse when a commit takes effect.
cfg_err  out  1  sticky flag: a commit was rejected.
frame_cnt  out  16  number of completed frames; wraps.
lines_last_frame  out  16  tlast count of the previous frame.

Behaviour:
- Beat: snoop_tvalid & snoop_tready. SOF: a beat with snoop_tuser = 1.
- Register map:
  - addr 0: staging threshold <= wr_data[DATA_WIDTH-1:0].
  - addr 1: staging upper <= wr_data[9:0].
  - addr 2: staging lower <= wr_data[9:0].
  - addr 3: wr_data[0] -> staging thr_en; wr_data[8] = 1 arms a commit; wr_data[9] = 1 clears cfg_err.
- Reset values:
  - Active and staging params = DEF_THR / DEF_UPPER / DEF_LOWER, thr_en = 1.
  - cfg_pending = 0, cfg_applied = 0, cfg_err = 0.
  - frame_cnt = 0, lines_last_frame = 0, line counter = 0, state = WAIT_SOF.
- FSM state WAIT_SOF:
  - Nothing is counted.
  - The first SOF moves to IN_FRAME and starts the line count at 0.
  - That first SOF does not increment frame_cnt.
- FSM state IN_FRAME:
  - Each beat with tlast increments the line counter; it saturates at 0xFFFF.
  - On each SOF: lines_last_frame <= line counter, counter <= 0, frame_cnt += 1 (wraps 0xFFFF -> 0).
  - The FSM stays in IN_FRAME.
- Commit on an SOF beat with cfg_pending = 1 (valid in either state):
  - If staging lower < staging upper: active params <= staging values, cfg_applied pulses the next cycle, cfg_pending <= 0.
  - Otherwise the commit is rejected: active params unchanged, cfg_err <= 1, cfg_pending <= 0, no cfg_applied pulse.
  - Latency: active outputs change on the clock edge that samples the SOF beat and are visible in the following cycle.
- Outputs are registered and stable between commits. Staging writes never affect the active outputs directly.
- Simultaneous events:
  - Staging write in the same cycle as a committing SOF: the commit uses the pre-write staging value, and the write lands in staging.
  - Arm (addr 3 bit 8) in the same cycle as an SOF: not consumed by that SOF; cfg_pending = 1 afterwards and the commit happens at the next SOF.
  - Arm while already pending: no change.
  - Error clear in the same cycle as a rejection: the rejection wins and cfg_err = 1.
- Reset mid-frame: everything returns to reset values immediately; the FSM re-synchronises on the next SOF.

Decomposition:
- Package hist_eq_pkg holds:
  - address localparams CFG_ADDR_THR, CFG_ADDR_UPPER, CFG_ADDR_LOWER, CFG_ADDR_CTRL;
  - bit indices CTRL_THR_EN = 0, CTRL_COMMIT = 8, CTRL_ERR_CLR = 9;
  - the FSM typedef enum {WAIT_SOF, IN_FRAME};
  - the bound width constant BOUND_W = 10.
- Sub-module hist_eq_frame_stats contains the snoop FSM and the line/frame counters.
- Commit and staging logic stay in the top module.

Test Plan:
1. Reset, then first frame of 4 lines, then SOF -> params = 128/717/205/1, frame_cnt = 1, lines_last_frame = 4.
2. Write upper = 800, lower = 100, thr = 60, ctrl = 0x100 mid-frame -> outputs unchanged and cfg_pending = 1 until the SOF beat; next cycle 60/800/100/0, cfg_applied high for exactly 1 cycle.
3. Write lower = 900, upper = 300, arm, SOF -> cfg_err = 1, params unchanged, no cfg_applied pulse; write ctrl = 0x200 -> cfg_err = 0.
4. Arm in the same cycle as an SOF beat -> no commit at that SOF; commit occurs at the following SOF.
5. SOF with tvalid = 1 but tready = 0 -> ignored (no commit, no count); same beat with tready = 1 -> counted.
6. Deassert reset during a frame with a commit pending -> all outputs return to reset values; the next SOF does not increment frame_cnt.
